// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Purpose  : Direct-mapped, write-back, write-allocate byte data cache that
//            sits between the cpu data port and a 32-bit block memory.
//            Hits finish with no stall. A miss stalls the cpu through an
//            optional dirty writeback and then a block fetch.
// Options  : DCACHE_STATS_EN adds the saturating hit_count/miss_count ports.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int ADDR_W      = 8,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic                busywait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_address,
  output logic [31:0]         mem_writedata,
  input  logic [31:0]         mem_readdata,
  input  logic                mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  localparam int TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [31:0]           r_data [NUM_BLOCKS];

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [OFFSET_BITS+2:0] w_bit_sel;
  logic [31:0]            w_block;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_idle_hit;
  logic                   w_write_hit;
  logic                   w_miss_start;
  logic                   w_fill;

  assign w_tag     = address[ADDR_W-1 -: TAG_W];
  assign w_index   = address[OFFSET_BITS +: INDEX_BITS];
  assign w_offset  = address[OFFSET_BITS-1:0];
  assign w_bit_sel = {w_offset, 3'b000};
  assign w_block   = r_data[w_index];
  assign w_req     = read | write;
  assign w_hit     = r_valid[w_index] & (r_tag[w_index] == w_tag);

  // A write takes precedence when read and write are both raised.
  assign w_idle_hit   = (r_state == S_IDLE) & w_req & w_hit;
  assign w_write_hit  = w_idle_hit & write;
  assign w_miss_start = (r_state == S_IDLE) & w_req & ~w_hit;
  assign w_fill       = (r_state == S_FETCH) & ~mem_busywait;

  // Reset forces the cpu-facing outputs quiet even while a request is held.
  assign busywait = ~RESET & w_req & ((r_state != S_IDLE) | ~w_hit);
  assign readdata = (~RESET & w_hit) ? w_block[w_bit_sel +: 8] : 8'h00;

  // Miss sequencer plus valid/dirty bookkeeping; memory-side outputs are registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
          end else if (w_miss_start) begin
            // dirty is only ever set on a valid line, so it alone decides eviction
            if (r_dirty[w_index]) begin
              r_state       <= S_WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {r_tag[w_index], w_index};
              mem_writedata <= w_block;
            end else begin
              r_state     <= S_FETCH;
              mem_read    <= 1'b1;
              mem_address <= {w_tag, w_index};
            end
          end
        end
        S_WRITEBACK: begin
          if (~mem_busywait) begin
            r_state     <= S_FETCH;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {w_tag, w_index};
          end
        end
        S_FETCH: begin
          if (~mem_busywait) begin
            r_state          <= S_IDLE;
            mem_read         <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays need no reset: an invalid line is never read as a hit.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_index] <= mem_readdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      r_data[w_index][w_bit_sel +: 8] <= writedata;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss event counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (w_idle_hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end
      if (w_miss_start && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Purpose  : Self-checking bench for data_cache. A transaction-level cache
//            model predicts hit/miss, memory traffic and load data; a latency
//            randomising memory responder serves the block port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } op_t;

  logic        CLK;
  logic        RESET;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // memory seen by the DUT, and the model's own idea of memory
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  // cache model
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  int          n_hit;
  int          n_miss;

  op_t ops[$];
  op_t exp_ops[$];

  logic [7:0] exp_rd;
  bit         exp_rd_on = 0;
  int         lat_lo = 0;
  int         lat_hi = 3;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic op_t mk_op(input logic wr, input logic [5:0] a, input logic [31:0] d);
    op_t o;
    o.wr = wr;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  function automatic op_t op_at(input int i);
    if (i < ops.size()) return ops[i];
    return '1;
  endfunction

  // memory responder: random wait states per request, data presented on negedge
  bit         armed = 0;
  logic [7:0] last_req;
  int         wait_left;
  always @(negedge CLK) begin
    if (!(mem_read || mem_write)) begin
      mem_busywait = 1'b0;
      armed = 0;
    end else begin
      if (!armed || ({mem_read, mem_write, mem_address} != last_req)) begin
        armed = 1;
        last_req = {mem_read, mem_write, mem_address};
        wait_left = $urandom_range(lat_hi, lat_lo);
      end
      if (wait_left > 0) begin
        mem_busywait = 1'b1;
        wait_left--;
      end else begin
        mem_busywait = 1'b0;
      end
      mem_readdata = mem[mem_address];
    end
  end

  // record every completed memory transfer
  always @(posedge CLK) begin
    if (!RESET && (mem_read || mem_write) && !mem_busywait) begin
      ops.push_back(mk_op(mem_write, mem_address, mem_write ? mem_writedata : 32'h0));
      if (mem_write) mem[mem_address] = mem_writedata;
    end
  end

  // per-cycle output checks
  always begin
    @(negedge CLK);
    #2;
    if (!RESET) begin
      chk("mem_rw_exclusive", {39'h0, mem_read & mem_write}, 40'h0);
      if (!read && !write) chk("idle_busywait", {39'h0, busywait}, 40'h0);
      if (exp_rd_on && read && !write && !busywait) chk("readdata", {32'h0, readdata}, {32'h0, exp_rd});
    end
  end

  // one cpu access, issued at a negedge, returns at a negedge
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd, output logic [7:0] got_rd);
    logic [2:0] idx;
    logic [2:0] tg;
    logic [1:0] off;
    bit         hit;
    int         n;
    idx = a[4:2];
    tg  = a[7:5];
    off = a[1:0];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_ops.delete();
    ops.delete();
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_ops.push_back(mk_op(1'b1, {m_tag[idx], idx}, m_data[idx]));
        ref_mem[{m_tag[idx], idx}] = m_data[idx];
      end
      exp_ops.push_back(mk_op(1'b0, {tg, idx}, 32'h0));
      m_data[idx]  = ref_mem[{tg, idx}];
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      n_miss++;
    end
    n_hit++;
    if (wr) begin
      m_data[idx][{off, 3'b000} +: 8] = wd;
      m_dirty[idx] = 1;
    end
    exp_rd = m_data[idx][{off, 3'b000} +: 8];
    read = !wr;
    write = wr;
    address = a;
    writedata = wd;
    exp_rd_on = !wr;
    #1;
    chk("busy_on_issue", {39'h0, busywait}, {39'h0, !hit});
    n = 0;
    while (busywait && n < 64) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("access_timeout", {39'h0, (n >= 64)}, 40'h0);
    got_rd = readdata;
    @(posedge CLK);
    @(negedge CLK);
    read = 0;
    write = 0;
    exp_rd_on = 0;
    chk("mem_op_count", 40'(ops.size()), 40'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size(); i++) chk("mem_op", {1'b0, op_at(i)}, {1'b0, exp_ops[i]});
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    RESET = 1;
    read = 0;
    write = 0;
    address = 0;
    writedata = 0;
    mem_busywait = 0;
    mem_readdata = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'hDDCCBBAA;  ref_mem[1] = 32'hDDCCBBAA;
    mem[9] = 32'h11223344;  ref_mem[9] = 32'h11223344;
    mem[4] = 32'h87654321;  ref_mem[4] = 32'h87654321;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i] = 0;
      m_data[i] = 0;
    end

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_mem_read", {39'h0, mem_read}, 40'h0);
    chk("rst_mem_write", {39'h0, mem_write}, 40'h0);
    RESET = 0;
    #1;
    chk("rst_busywait", {39'h0, busywait}, 40'h0);
    chk("rst_readdata", {32'h0, readdata}, 40'h0);
    @(negedge CLK);

    // reset in the middle of a fetch aborts it
    lat_lo = 6;
    lat_hi = 6;
    read = 1;
    address = 8'h05;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("t1_fetch_started", {39'h0, mem_read}, 40'h1);
    #1 RESET = 1;
    #1;
    chk("t1_rst_mem_read", {39'h0, mem_read}, 40'h0);
    chk("t1_rst_busywait", {39'h0, busywait}, 40'h0);
    chk("t1_rst_mem_write", {39'h0, mem_write}, 40'h0);
    @(negedge CLK);
    RESET = 0;
    read = 0;
    @(negedge CLK);
    lat_lo = 0;
    lat_hi = 3;
    n_hit = 0;
    n_miss = 0;

    // cold read of 0x05 misses again and fetches block 1
    access(0, 8'h05, 8'h00, rd);
    chk("t2_readdata", {32'h0, rd}, {32'h0, 8'hBB});
    chk("t2_ops", 40'(ops.size()), 40'd1);
    chk("t2_fetch", {1'b0, op_at(0)}, {1'b0, mk_op(1'b0, 6'h01, 32'h0)});

    // write hit then read hit, no memory traffic
    access(1, 8'h06, 8'h5A, rd);
    chk("t3_write_ops", 40'(ops.size()), 40'd0);
    access(0, 8'h06, 8'h00, rd);
    chk("t3_readdata", {32'h0, rd}, {32'h0, 8'h5A});
    chk("t3_read_ops", 40'(ops.size()), 40'd0);

    // conflicting read evicts dirty block 1
    access(0, 8'h25, 8'h00, rd);
    chk("t4_ops", 40'(ops.size()), 40'd2);
    chk("t4_writeback", {1'b0, op_at(0)}, {1'b0, mk_op(1'b1, 6'h01, 32'hDD5ABBAA)});
    chk("t4_fetch", {1'b0, op_at(1)}, {1'b0, mk_op(1'b0, 6'h09, 32'h0)});
    chk("t4_readdata", {32'h0, rd}, {32'h0, 8'h33});
`ifdef DCACHE_STATS_EN
    chk("t6_miss_count", {24'h0, miss_count}, 40'(n_miss));
    chk("t6_hit_count", {24'h0, hit_count}, 40'(n_hit));
`endif

    // write miss on a clean line: fetch only, then the byte lands
    access(1, 8'h10, 8'h3C, rd);
    chk("t5_ops", 40'(ops.size()), 40'd1);
    chk("t5_fetch", {1'b0, op_at(0)}, {1'b0, mk_op(1'b0, 6'h04, 32'h0)});
    access(0, 8'h10, 8'h00, rd);
    chk("t5_readback", {32'h0, rd}, {32'h0, 8'h3C});
    access(0, 8'h11, 8'h00, rd);
    chk("t5_neighbour", {32'h0, rd}, {32'h0, 8'h43});

    // random traffic
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(2, 0)) @(negedge CLK);
      access(bit'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), rd);
    end

`ifdef DCACHE_STATS_EN
    chk("end_miss_count", {24'h0, miss_count}, 40'(n_miss));
    chk("end_hit_count", {24'h0, hit_count}, 40'(n_hit));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the stimulus stalls somewhere unexpected
  initial begin
    #2000000;
    $display("FAIL global_timeout: got stalled run expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
